// File: rtl/ram_port_initiator_if.sv
// RAM-style port bus between an initiator and a responder bank.
// Responder registers ram_q one clock after ram_req; writes land on the request edge.
interface ram_port_initiator_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_d;
    logic                  ram_req;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [ADDR_WIDTH-1:0] ram_len;

    modport master (
        output ram_addr, ram_d, ram_req, ram_we,
        input  ram_q, ram_len
    );

    modport slave (
        input  ram_addr, ram_d, ram_req, ram_we,
        output ram_q, ram_len
    );
endinterface

// File: rtl/ram_port_initiator.sv
// Block read/write initiator: sweeps a clamped address range on the RAM port
// and bridges it to valid/ready read and write streams.
module ram_port_initiator #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_start,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_count,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    ram_port_initiator_if.master  ram
);
    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_CAP, RD_HOLD, WR_WAIT, WR_ISSUE, DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_n;
    logic [ADDR_WIDTH:0]   remaining, remaining_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [DATA_WIDTH-1:0] d_q, d_n;
    logic                  req_q, req_n;
    logic                  we_q, we_n;
    logic                  busy_n, done_n, rd_valid_n, wr_ready_n;
    logic [DATA_WIDTH-1:0] rd_data_n;
    logic [ADDR_WIDTH:0]   base_x, len_x, avail, eff;

    assign ram.ram_addr = addr_q;
    assign ram.ram_d    = d_q;
    assign ram.ram_req  = req_q;
    assign ram.ram_we   = we_q;

    // Clamp the request to the implemented part of the port bank.
    always_comb begin
        base_x = {1'b0, cmd_base};
        len_x  = {1'b0, ram.ram_len};
        avail  = (base_x < len_x) ? (len_x - base_x) : '0;
        eff    = (cmd_count < avail) ? cmd_count : avail;
    end

    always_comb begin
        state_n     = state;
        cur_addr_n  = cur_addr;
        remaining_n = remaining;
        addr_n      = addr_q;
        d_n         = d_q;
        req_n       = 1'b0;
        we_n        = 1'b0;
        busy_n      = busy;
        done_n      = 1'b0;
        rd_valid_n  = rd_valid;
        rd_data_n   = rd_data;
        wr_ready_n  = wr_ready;
        unique case (state)
            IDLE: begin
                if (cmd_start) begin
                    cur_addr_n  = cmd_base;
                    remaining_n = eff;
                    busy_n      = 1'b1;
                    if (eff == '0) begin
                        state_n = DONE;
                    end else if (cmd_write) begin
                        wr_ready_n = 1'b1;
                        state_n    = WR_WAIT;
                    end else begin
                        addr_n  = cmd_base;
                        req_n   = 1'b1;
                        state_n = RD_REQ;
                    end
                end
            end
            RD_REQ: state_n = RD_CAP;
            RD_CAP: begin
                rd_data_n  = ram.ram_q;
                rd_valid_n = 1'b1;
                state_n    = RD_HOLD;
            end
            RD_HOLD: begin
                if (rd_valid && rd_ready) begin
                    rd_valid_n  = 1'b0;
                    remaining_n = remaining - CNT_ONE;
                    if (remaining == CNT_ONE) begin
                        state_n = DONE;
                    end else begin
                        cur_addr_n = cur_addr + 1'b1;
                        addr_n     = cur_addr + 1'b1;
                        req_n      = 1'b1;
                        state_n    = RD_REQ;
                    end
                end
            end
            WR_WAIT: begin
                if (wr_valid && wr_ready) begin
                    addr_n     = cur_addr;
                    d_n        = wr_data;
                    req_n      = 1'b1;
                    we_n       = 1'b1;
                    wr_ready_n = 1'b0;
                    state_n    = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                remaining_n = remaining - CNT_ONE;
                cur_addr_n  = cur_addr + 1'b1;
                if (remaining == CNT_ONE) begin
                    state_n = DONE;
                end else begin
                    wr_ready_n = 1'b1;
                    state_n    = WR_WAIT;
                end
            end
            DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            addr_q    <= '0;
            d_q       <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            wr_ready  <= 1'b0;
        end else begin
            state     <= state_n;
            cur_addr  <= cur_addr_n;
            remaining <= remaining_n;
            addr_q    <= addr_n;
            d_q       <= d_n;
            req_q     <= req_n;
            we_q      <= we_n;
            busy      <= busy_n;
            done      <= done_n;
            rd_valid  <= rd_valid_n;
            rd_data   <= rd_data_n;
            wr_ready  <= wr_ready_n;
        end
    end
endmodule

// File: tb/tb_ram_port_initiator.sv
// Directed bench for ram_port_initiator with a behavioural port-bank responder.
// Checks latency, clamping, backpressure, write bursts, reset and busy starts.
module tb_ram_port_initiator;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_start, cmd_write;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_count;
    logic          busy, done;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_ready;

    ram_port_initiator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram ();

    ram_port_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_start(cmd_start), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .busy(busy), .done(done),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .ram(ram.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // responder: ten implemented ports, read bank and write bank kept apart
    logic [DW-1:0] in_ports  [16];
    logic [DW-1:0] out_ports [16];
    assign ram.ram_len = 4'd10;
    always @(posedge clk) begin
        if (ram.ram_req) begin
            if (ram.ram_we) out_ports[ram.ram_addr] <= ram.ram_d;
            else            ram.ram_q <= in_ports[ram.ram_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // protocol monitor, sampled on the falling edge
    int            req_cyc[$];
    int            vld_cyc[$];
    logic [DW-1:0] rdq[$];
    int            done_cnt = 0;
    int            viol_b2b = 0, viol_addr = 0, viol_we = 0;
    int            viol_stall = 0, viol_rdreq = 0;
    logic          prev_req = 1'b0, prev_vld = 1'b0, prev_rdy = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (ram.ram_req) begin
                req_cyc.push_back(cyc);
                if (prev_req) viol_b2b++;
                if (ram.ram_addr >= ram.ram_len) viol_addr++;
                if (rd_valid) viol_rdreq++;
            end
            if (ram.ram_we && !ram.ram_req) viol_we++;
            if (rd_valid && !prev_vld) vld_cyc.push_back(cyc);
            if (rd_valid && prev_vld && !prev_rdy && rd_data != prev_data)
                viol_stall++;
            if (rd_valid && rd_ready) rdq.push_back(rd_data);
            if (done) done_cnt++;
        end
        prev_req  = ram.ram_req;
        prev_vld  = rd_valid;
        prev_rdy  = rd_ready;
        prev_data = rd_data;
    end

    int s_cyc;

    task automatic start(input logic w, input logic [AW-1:0] b,
                         input logic [AW:0] c);
        @(posedge clk); #1;
        cmd_start = 1'b1; cmd_write = w; cmd_base = b; cmd_count = c;
        s_cyc = cyc;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int lat);
        bit seen = 0;
        lat = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                lat  = cyc - s_cyc;
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        bit hs = 0;
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_data = d;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = wr_ready;
            @(posedge clk); #1;
        end
        if (!hs) check("wr_hs_timeout", 32'd0, 32'd1);
        wr_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    int b_req, b_rd, b_vld, b_done, lat;

    task automatic mark();
        b_req  = req_cyc.size();
        b_rd   = rdq.size();
        b_vld  = vld_cyc.size();
        b_done = done_cnt;
    endtask

    initial begin
        rst = 1'b0;
        cmd_start = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_count = '0;
        rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
        for (int i = 0; i < 16; i++) begin
            in_ports[i]  = 8'(10 + i);
            out_ports[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {busy, done, rd_valid, wr_ready, ram.ram_req, ram.ram_we}, 0);
        check("rst_data", {ram.ram_addr, ram.ram_d, rd_data}, 0);
        @(negedge clk); rst = 1'b1;
        repeat (4) @(posedge clk);
        check("idle_no_req", req_cyc.size(), 0);

        // read sweep of the whole bank
        rd_ready = 1'b1;
        mark();
        start(1'b0, 4'd0, 5'd10);
        wait_done("sweep", lat);
        check("sweep_words", rdq.size() - b_rd, 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("sweep_d%0d", i), rdq[b_rd + i], 10 + i);
        check("sweep_req_lat", req_cyc[b_req] - s_cyc, 1);
        check("sweep_vld_lat", vld_cyc[b_vld] - s_cyc, 3);
        check("sweep_reqs", req_cyc.size() - b_req, 10);
        check("sweep_dones", done_cnt - b_done, 1);
        check("sweep_busy", busy, 0);

        // clamped read at the end of the bank
        mark();
        start(1'b0, 4'd7, 5'd8);
        wait_done("clamp", lat);
        check("clamp_words", rdq.size() - b_rd, 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("clamp_d%0d", i), rdq[b_rd + i], 17 + i);
        check("clamp_reqs", req_cyc.size() - b_req, 3);

        // base past the bank: empty command
        mark();
        start(1'b0, 4'd10, 5'd4);
        wait_done("empty", lat);
        check("empty_lat", lat, 2);
        check("empty_reqs", req_cyc.size() - b_req, 0);
        check("empty_dones", done_cnt - b_done, 1);

        // backpressure: ready low for two valid cycles of each word
        rd_ready = 1'b0;
        mark();
        start(1'b0, 4'd2, 5'd3);
        for (int w = 0; w < 3; w++) begin
            bit got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                if (rd_valid) got = 1;
                else begin @(posedge clk); #1; end
            end
            if (!got) check("bp_vld_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            @(posedge clk); #1;
            rd_ready = 1'b1;
            @(posedge clk); #1;
            rd_ready = 1'b0;
        end
        wait_done("bp", lat);
        check("bp_words", rdq.size() - b_rd, 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("bp_d%0d", i), rdq[b_rd + i], 12 + i);
        check("bp_reqs", req_cyc.size() - b_req, 3);

        // write burst with gaps
        mark();
        start(1'b1, 4'd4, 5'd3);
        send_word(8'h55);
        send_word(8'hAA);
        send_word(8'h0F);
        wait_done("wr", lat);
        check("wr_p4", out_ports[4], 8'h55);
        check("wr_p5", out_ports[5], 8'hAA);
        check("wr_p6", out_ports[6], 8'h0F);
        check("wr_p3", out_ports[3], 8'h00);
        check("wr_p7", out_ports[7], 8'h00);
        check("wr_reqs", req_cyc.size() - b_req, 3);
        check("wr_no_rd", rdq.size() - b_rd, 0);
        check("wr_d_hold", ram.ram_d, 8'h0F);

        // asynchronous reset while a read word is stalled
        start(1'b0, 4'd0, 5'd5);
        begin
            bit got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(posedge clk); #1;
                if (rd_valid) got = 1;
            end
            if (!got) check("rst_vld_timeout", 32'd0, 32'd1);
        end
        #3 rst = 1'b0;
        #1;
        check("mid_rst_ctrl", {busy, done, rd_valid, wr_ready, ram.ram_req, ram.ram_we}, 0);
        check("mid_rst_data", {ram.ram_addr, ram.ram_d, rd_data}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        mark();
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_no_req", req_cyc.size() - b_req, 0);
        rd_ready = 1'b1;
        start(1'b0, 4'd3, 5'd2);
        wait_done("post_rst", lat);
        check("post_rst_words", rdq.size() - b_rd, 2);
        check("post_rst_d0", rdq[b_rd], 13);
        check("post_rst_d1", rdq[b_rd + 1], 14);

        // start while busy is ignored
        mark();
        start(1'b1, 4'd0, 5'd2);
        send_word(8'hC3);
        start(1'b0, 4'd5, 5'd3);
        send_word(8'h3C);
        wait_done("busy_start", lat);
        repeat (6) @(posedge clk);
        #1;
        check("bs_p0", out_ports[0], 8'hC3);
        check("bs_p1", out_ports[1], 8'h3C);
        check("bs_reqs", req_cyc.size() - b_req, 2);
        check("bs_dones", done_cnt - b_done, 1);
        check("bs_no_rd", rdq.size() - b_rd, 0);
        check("bs_busy", busy, 0);

        check("viol_b2b", viol_b2b, 0);
        check("viol_addr", viol_addr, 0);
        check("viol_we", viol_we, 0);
        check("viol_stall", viol_stall, 0);
        check("viol_rdreq", viol_rdreq, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_port_initiator.md
Name: ram_port_initiator

Overview:
- Initiator (master) side of the single-port RAM-style I/O handshake: ram_addr, ram_d, ram_req, ram_we, ram_q and ram_len.
- Sits between a streaming datapath and a memory-mapped port bank. For reads it sweeps a block of addresses and emits each returned word on a valid/ready stream. For writes it takes words from a valid/ready stream and writes them to successive addresses.
- The responder registers ram_q one clock after a request and applies writes on the request edge.

Parameters:
- DATA_WIDTH, 8, width of every data word.
- ADDR_WIDTH, 4, width of the port address; transfer counts are ADDR_WIDTH+1 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_start  in  1  start pulse; sampled only in IDLE.
- cmd_write  in  1  1 = write block, 0 = read block; sampled with cmd_start.
- cmd_base  in  ADDR_WIDTH  first address.
- cmd_count  in  ADDR_WIDTH+1  number of words requested.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- done  out  1  one-cycle pulse at the end of every accepted command.
- rd_data  out  DATA_WIDTH  read stream data.
- rd_valid  out  1  read stream valid.
- rd_ready  in  1  read stream ready.
- wr_data  in  DATA_WIDTH  write stream data.
- wr_valid  in  1  write stream valid.
- wr_ready  out  1  write stream ready.
- ram_addr  out  ADDR_WIDTH  responder address.
- ram_d  out  DATA_WIDTH  responder write data.
- ram_req  out  1  responder request.
- ram_we  out  1  responder write enable.
- ram_q  in  DATA_WIDTH  responder read data, valid the cycle after ram_req.
- ram_len  in  ADDR_WIDTH  number of implemented responder addresses.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous, any state): state=IDLE. busy, done, rd_valid, wr_ready, ram_req, ram_we = 0. ram_addr, ram_d, rd_data = 0. Internal cur_addr and remaining = 0. No request is issued after reset is released until a new cmd_start.
- States: IDLE, RD_REQ, RD_CAP, RD_HOLD, WR_WAIT, WR_ISSUE, DONE.
- Clamping, computed at start in ADDR_WIDTH+1-bit arithmetic:
  - eff = min(cmd_count, ram_len - cmd_base).
  - eff = 0 if cmd_base >= ram_len.
  - eff = 0 goes straight to DONE with no ram_req.
- IDLE, on cmd_start=1:
  - Set cur_addr=cmd_base, remaining=eff, busy<=1.
  - Read with eff>0: ram_addr<=cmd_base, ram_req<=1, go to RD_REQ.
  - Write with eff>0: wr_ready<=1, go to WR_WAIT.
- RD_REQ (ram_req high this cycle): ram_req<=0, go to RD_CAP.
- RD_CAP: rd_data<=ram_q, rd_valid<=1, go to RD_HOLD.
- RD_HOLD:
  - rd_data is held stable while rd_valid=1 and rd_ready=0.
  - On rd_valid&&rd_ready: rd_valid<=0, remaining-=1.
  - If remaining was 1, go to DONE.
  - Otherwise cur_addr+=1, ram_addr<=cur_addr+1, ram_req<=1, go to RD_REQ.
  - Read latency: cmd_start in cycle 0 gives ram_req in cycle 1 and rd_valid in cycle 3. Peak rate is 1 word per 3 cycles.
- WR_WAIT:
  - On wr_valid&&wr_ready: ram_addr<=cur_addr, ram_d<=wr_data, ram_req<=1, ram_we<=1, wr_ready<=0, go to WR_ISSUE.
- WR_ISSUE:
  - ram_req<=0, ram_we<=0, remaining-=1, cur_addr+=1.
  - If remaining was 1, go to DONE; otherwise wr_ready<=1, go to WR_WAIT.
  - Peak rate is 1 word per 2 cycles.
- DONE: done=1 for exactly this cycle, busy<=0, go to IDLE.
- cmd_start while busy or in DONE is ignored; no queuing.
- ram_we is never high without ram_req.
- ram_req is never high for two consecutive cycles.
- Addresses never exceed ram_len-1, so no wrap-around occurs.
- ram_d holds its last value when not writing.

Test Plan:
- Read sweep: responder holds in_io_ports0..9 = 10..19, ram_len=10, base=0, count=10, rd_ready=1 -> rd_data sequence 10..19, first rd_valid 3 cycles after start, exactly 10 ram_req pulses, one done pulse, busy low after done.
- Clamp and empty: base=7, count=8, ram_len=10 -> exactly 3 words from addresses 7,8,9. Then base=10, count=4 -> done 2 cycles after start with zero ram_req pulses.
- Backpressure: read base=2, count=3, rd_ready toggled 0,0,1 per word -> rd_data stable while stalled, no new ram_req until each handshake, values in_io_ports2..4.
- Write burst with gaps: write base=4, count=3, wr_data 0x55, 0xAA, 0x0F, wr_valid deasserted 2 cycles between words -> out_io_ports4..6 = 0x55, 0xAA, 0x0F, ram_we high only with ram_req, other outputs unchanged.
- Reset mid-operation: assert rst=0 during RD_HOLD of a 5-word read -> all outputs 0 immediately. After release, no ram_req until a new start, and a new 2-word read completes normally.
- Start while busy: second cmd_start during a write burst -> ignored. Burst completes with its original count, and exactly one done pulse.
